// File: rtl/vga_timing_pkg.sv
// VGA 800x600@60 timing constants and the per-pixel flag record carried down the display pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_ACT  = 800;
    localparam int H_FP   = 40;
    localparam int H_SYNC = 128;
    localparam int H_BP   = 88;
    localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;   // 1056

    // Vertical timing in lines
    localparam int V_ACT  = 600;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 4;
    localparam int V_BP   = 23;
    localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;   // 628

    // Both syncs are active-high for this mode
    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b1;

    // Flags decoded from the counters, delayed to meet the returned pixel
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic in_img;
        logic fst;
    } disp_flags_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with decoded active-video, sync and frame-start flags.
// Latency: flags are combinational from the counters (0 cycles).
// Backpressure: none; the raster never stalls.
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt,
    output logic        active,
    output logic        hs,
    output logic        vs,
    output logic        fst
);

    localparam logic [10:0] H_LAST = 11'(H_TOT - 1);
    localparam logic [10:0] H_AEND = 11'(H_ACT);
    localparam logic [10:0] HS_BEG = 11'(H_ACT + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0]  V_AEND = 10'(V_ACT);
    localparam logic [9:0]  VS_BEG = 10'(V_ACT + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACT + V_FP + V_SYNC);

    // Raster scan: h wraps every line, v advances (and wraps) on the h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign active = (h_cnt < H_AEND) && (v_cnt < V_AEND);
    assign hs     = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    assign vs     = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    assign fst    = (h_cnt == 11'd0) && (v_cnt == 10'd0);

endmodule

// File: rtl/vga_disp_ctr.sv
// Display stage: VGA raster, one BRAM read per image pixel, gray-to-RGB mux with centred image.
// Latency: counter to pins RD_LAT+1 cycles for every output (pixel data meets flags after RD_LAT).
// Backpressure: none; the reader must return each pixel exactly RD_LAT cycles after its request.
module vga_disp_ctr
    import vga_timing_pkg::*;
#(
    parameter int         MAX_ROW = 540,
    parameter int         MAX_COL = 540,
    parameter int         IMG_X0  = 130,
    parameter int         IMG_Y0  = 30,
    parameter int         RD_LAT  = 2,
    parameter logic [7:0] BG_GRAY = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       bram_en_o,
    input  logic [7:0] pixel_i,
    input  logic       pixel_en_i,
    output logic [3:0] vga_r_o,
    output logic [3:0] vga_g_o,
    output logic [3:0] vga_b_o,
    output logic       vga_hs_o,
    output logic       vga_vs_o,
    output logic       frame_st_o,
    output logic       sync_err_o
);

    // Image must fit inside active video, and the flag pipe needs at least one stage
    if (IMG_X0 + MAX_COL > H_ACT) begin : g_chk_x
        $error("vga_disp_ctr: IMG_X0+MAX_COL exceeds active width");
    end
    if (IMG_Y0 + MAX_ROW > V_ACT) begin : g_chk_y
        $error("vga_disp_ctr: IMG_Y0+MAX_ROW exceeds active height");
    end
    if (RD_LAT < 1) begin : g_chk_lat
        $error("vga_disp_ctr: RD_LAT must be at least 1");
    end

    localparam logic [10:0] X_LO   = 11'(IMG_X0);
    localparam logic [10:0] X_HI   = 11'(IMG_X0 + MAX_COL);
    localparam logic [9:0]  Y_LO   = 10'(IMG_Y0);
    localparam logic [9:0]  Y_HI   = 10'(IMG_Y0 + MAX_ROW);
    localparam logic [3:0]  BG_NIB = BG_GRAY[7:4];

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        active;
    logic        hs;
    logic        vs;
    logic        fst;
    logic        in_img;
    disp_flags_t cur_flags;
    disp_flags_t flag_pipe [RD_LAT];
    disp_flags_t al_flags;
    logic [3:0]  gray_nib;
    logic        unused_pix_lsb;

    vga_timing_gen u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs),
        .fst    (fst)
    );

    // Exactly MAX_COL*MAX_ROW requests per frame, so the reader address wraps on frame boundaries
    assign in_img    = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
    assign bram_en_o = rst_n & in_img;

    assign cur_flags = {active, hs, vs, in_img, fst};
    assign al_flags  = flag_pipe[RD_LAT-1];

    // Only the top nibble of the gray value reaches the 4-bit DAC
    assign unused_pix_lsb = ^pixel_i[3:0];

    // Delay the decoded flags by the read latency so they line up with pixel_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                flag_pipe[i] <= '0;
            end
        end else begin
            flag_pipe[0] <= cur_flags;
            for (int i = 1; i < RD_LAT; i++) begin
                flag_pipe[i] <= flag_pipe[i-1];
            end
        end
    end

    // Pixel mux: image pixel inside the window, background elsewhere in active video, black in blanking
    always_comb begin
        gray_nib = 4'h0;
        if (al_flags.active) begin
            gray_nib = al_flags.in_img ? pixel_i[7:4] : BG_NIB;
        end
    end

    // Output register; sync error is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_o    <= '0;
            vga_g_o    <= '0;
            vga_b_o    <= '0;
            vga_hs_o   <= 1'b0;
            vga_vs_o   <= 1'b0;
            frame_st_o <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            vga_r_o    <= gray_nib;
            vga_g_o    <= gray_nib;
            vga_b_o    <= gray_nib;
            vga_hs_o   <= al_flags.hs;
            vga_vs_o   <= al_flags.vs;
            frame_st_o <= al_flags.fst;
            if (pixel_en_i != al_flags.in_img) begin
                sync_err_o <= 1'b1;
            end
        end
    end

endmodule
